// File: rtl/pkt_seq_scheduler_if.sv
// Framed packet bus between requesters/checker and the scheduler.
// The master side drives requests, payloads and the error flag; the slave side is the scheduler.
interface pkt_seq_scheduler_if #(
    parameter int BUS_SIZE  = 16,
    parameter int WORD_SIZE = 4,
    parameter int NUM_REQ   = 4
);
    localparam int PAY_W = BUS_SIZE - 2 * WORD_SIZE;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*PAY_W-1:0] payload;
    logic                     err_in;
    logic [NUM_REQ-1:0]       gnt;
    logic [BUS_SIZE-1:0]      data_bus;
    logic                     valid;
    logic                     resync;

    modport master (
        output req, payload, err_in,
        input  gnt, data_bus, valid, resync
    );

    modport slave (
        input  req, payload, err_in,
        output gnt, data_bus, valid, resync
    );
endinterface

// File: rtl/pkt_seq_scheduler.sv
// Round-robin source scheduler: frames the granted payload as {F_CODE, payload, seq}
// and restarts the sequence at 0 after a checker error plus a fixed idle gap.
module pkt_seq_scheduler #(
    parameter int BUS_SIZE   = 16,
    parameter int WORD_SIZE  = 4,
    parameter int NUM_REQ    = 4,
    parameter int RESYNC_GAP = 2
) (
    input  logic              clk,
    input  logic              reset,
    pkt_seq_scheduler_if.slave bus
);
    localparam int PAY_W = BUS_SIZE - 2 * WORD_SIZE;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = $clog2(RESYNC_GAP + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEND   = 2'd1;
    localparam logic [1:0] S_RESYNC = 2'd2;

    logic [1:0]           state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [WORD_SIZE-1:0] seq;
    logic [GAP_W-1:0]     gap_cnt;

    logic                 grant_any;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W:0]       cand;
    logic [NUM_REQ-1:0]   gnt_c;
    logic [PAY_W-1:0]     pay_sel;

    logic [BUS_SIZE-1:0]  data_p1;
    logic                 vld_p1;
    logic                 resync_p1;

    function automatic logic [BUS_SIZE-1:0] frame_word(input logic [PAY_W-1:0] pay,
                                                       input logic [WORD_SIZE-1:0] sq);
        frame_word = {{WORD_SIZE{1'b1}}, pay, sq};
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        next_ptr = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Combinational arbitration: search starts at rr_ptr and wraps modulo NUM_REQ
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        gnt_c     = '0;
        pay_sel   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ))
                cand = cand - (PTR_W+1)'(NUM_REQ);
            if (!grant_any && bus.req[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        // An error in the same cycle wins over any request; the payload stays unconsumed
        if (reset || bus.err_in || state == S_RESYNC)
            grant_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i))
                pay_sel = bus.payload[i*PAY_W +: PAY_W];
        end
        if (grant_any)
            gnt_c[grant_idx] = 1'b1;
    end

    assign bus.gnt = gnt_c;

    // Stage p1: registered framed word, valid and resync pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            seq       <= WORD_SIZE'(1);
            gap_cnt   <= '0;
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            resync_p1 <= 1'b0;
        end else begin
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            resync_p1 <= 1'b0;
            case (state)
                S_RESYNC: begin
                    if (gap_cnt == GAP_W'(RESYNC_GAP - 1)) begin
                        gap_cnt   <= '0;
                        seq       <= '0;
                        resync_p1 <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    if (bus.err_in) begin
                        gap_cnt <= '0;
                        state   <= S_RESYNC;
                    end else if (grant_any) begin
                        data_p1 <= frame_word(pay_sel, seq);
                        vld_p1  <= 1'b1;
                        seq     <= seq + 1'b1;
                        rr_ptr  <= next_ptr(grant_idx);
                        state   <= S_SEND;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.data_bus = data_p1;
    assign bus.valid    = vld_p1;
    assign bus.resync   = resync_p1;
endmodule

// File: tb/tb_pkt_seq_scheduler.sv
// Directed bench for pkt_seq_scheduler: framing, round-robin order, wrap,
// error resynchronisation and asynchronous reset, with hand-computed expectations.
module tb_pkt_seq_scheduler;
    localparam int BUS_SIZE   = 16;
    localparam int WORD_SIZE  = 4;
    localparam int NUM_REQ    = 4;
    localparam int RESYNC_GAP = 2;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    pkt_seq_scheduler_if #(.BUS_SIZE(BUS_SIZE), .WORD_SIZE(WORD_SIZE), .NUM_REQ(NUM_REQ)) bus ();

    pkt_seq_scheduler #(
        .BUS_SIZE(BUS_SIZE), .WORD_SIZE(WORD_SIZE), .NUM_REQ(NUM_REQ), .RESYNC_GAP(RESYNC_GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // At most one grant bit high at any sampled point
    always @(negedge clk) begin
        if (!$onehot0(bus.gnt)) begin
            miscompares++;
            $display("FAIL gnt_onehot: gnt=%b is not zero/one-hot", bus.gnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = '0; bus.payload = '0; bus.err_in = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 4'b0001; bus.payload = '0; bus.err_in = 1'b0;
        bus.payload[7:0] = 8'hA5;
        #2;
        vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        tick();
        vectors++; if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        vectors++; if (bus.data_bus !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got %h want 0000", bus.data_bus); end
        vectors++; if (bus.resync !== 1'b0) begin miscompares++; $display("FAIL reset_resync: got %b want 0", bus.resync); end
    endtask

    task automatic test_single();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'hFA51; exp_w[1] = 16'hFA52; exp_w[2] = 16'hFA53;
        do_reset();
        bus.req = 4'b0001; bus.payload[7:0] = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL single_gnt[%0d]: got %b want 0001", k, bus.gnt); end
            tick();
            vectors++; if (bus.data_bus !== exp_w[k] || bus.valid !== 1'b1) begin
                miscompares++; $display("FAIL single_word[%0d]: got %h/%b want %h/1", k, bus.data_bus, bus.valid, exp_w[k]); end
        end
        bus.req = '0;
        #1;
        vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL single_noreq_gnt: got %b want 0000", bus.gnt); end
        tick();
        vectors++; if (bus.valid !== 1'b0 || bus.data_bus !== 16'h0000) begin
            miscompares++; $display("FAIL single_idle: got %h/%b want 0000/0", bus.data_bus, bus.valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g [5];
        logic [15:0] exp_w [5];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_w[0] = 16'hF111; exp_w[1] = 16'hF222; exp_w[2] = 16'hF333; exp_w[3] = 16'hF444; exp_w[4] = 16'hF115;
        do_reset();
        bus.req = 4'b1111; bus.payload = 32'h44_33_22_11;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++; if (bus.gnt !== exp_g[k]) begin miscompares++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, bus.gnt, exp_g[k]); end
            tick();
            vectors++; if (bus.data_bus !== exp_w[k] || bus.valid !== 1'b1) begin
                miscompares++; $display("FAIL rr_word[%0d]: got %h/%b want %h/1", k, bus.data_bus, bus.valid, exp_w[k]); end
        end
        bus.req = '0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_seq;
        do_reset();
        bus.req = 4'b0001; bus.payload[7:0] = 8'h3C;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_seq = 4'(k);
            vectors++; if (bus.valid !== 1'b1 || bus.data_bus !== {4'hF, 8'h3C, exp_seq}) begin
                miscompares++; $display("FAIL b2b_word[%0d]: got %h/%b want %h/1", k, bus.data_bus, bus.valid, {4'hF, 8'h3C, exp_seq}); end
        end
        bus.req = '0;
    endtask

    task automatic test_err_resync();
        do_reset();
        bus.req = 4'b0001; bus.payload[7:0] = 8'hA5;
        tick();
        bus.err_in = 1'b1;
        #1;
        vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL err_gnt: got %b want 0000", bus.gnt); end
        vectors++; if (bus.data_bus !== 16'hFA51 || bus.valid !== 1'b1) begin
            miscompares++; $display("FAIL err_word_kept: got %h/%b want FA51/1", bus.data_bus, bus.valid); end
        tick();
        bus.err_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++; if (bus.valid !== 1'b0 || bus.data_bus !== 16'h0000 || bus.gnt !== 4'b0000 || bus.resync !== 1'b0) begin
                miscompares++; $display("FAIL err_gap[%0d]: got data=%h valid=%b gnt=%b resync=%b want 0000/0/0000/0",
                                        k, bus.data_bus, bus.valid, bus.gnt, bus.resync); end
            if (k == 0) bus.err_in = 1'b1;  // a second error inside the gap must not restart it
            tick();
            bus.err_in = 1'b0;
        end
        vectors++; if (bus.resync !== 1'b1 || bus.valid !== 1'b0) begin
            miscompares++; $display("FAIL err_resync_pulse: got resync=%b valid=%b want 1/0", bus.resync, bus.valid); end
        vectors++; if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL err_regrant: got %b want 0001", bus.gnt); end
        tick();
        vectors++; if (bus.data_bus !== 16'hFA50 || bus.valid !== 1'b1 || bus.resync !== 1'b0) begin
            miscompares++; $display("FAIL err_seq0: got %h/%b resync=%b want FA50/1/0", bus.data_bus, bus.valid, bus.resync); end
        tick();
        vectors++; if (bus.data_bus !== 16'hFA51) begin miscompares++; $display("FAIL err_seq1: got %h want FA51", bus.data_bus); end
        bus.req = '0;
    endtask

    task automatic test_err_with_req();
        do_reset();
        bus.req = 4'b0100; bus.payload[23:16] = 8'h77; bus.err_in = 1'b1;
        #1;
        vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL errreq_gnt: got %b want 0000", bus.gnt); end
        tick();
        bus.err_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            vectors++; if (bus.gnt !== 4'b0000 || bus.valid !== 1'b0) begin
                miscompares++; $display("FAIL errreq_gap[%0d]: got gnt=%b valid=%b want 0000/0", k, bus.gnt, bus.valid); end
            tick();
        end
        vectors++; if (bus.resync !== 1'b1 || bus.gnt !== 4'b0100) begin
            miscompares++; $display("FAIL errreq_resync: got resync=%b gnt=%b want 1/0100", bus.resync, bus.gnt); end
        tick();
        vectors++; if (bus.data_bus !== 16'hF770 || bus.valid !== 1'b1) begin
            miscompares++; $display("FAIL errreq_word: got %h/%b want F770/1", bus.data_bus, bus.valid); end
        bus.req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req = 4'b0011; bus.payload[7:0] = 8'hA5; bus.payload[15:8] = 8'hB6;
        tick();
        vectors++; if (bus.data_bus !== 16'hFA51 || bus.gnt !== 4'b0010) begin
            miscompares++; $display("FAIL mid_pre: got %h gnt=%b want FA51/0010", bus.data_bus, bus.gnt); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (bus.valid !== 1'b0 || bus.data_bus !== 16'h0000 || bus.gnt !== 4'b0000) begin
            miscompares++; $display("FAIL mid_async_clear: got %h/%b gnt=%b want 0000/0/0000", bus.data_bus, bus.valid, bus.gnt); end
        tick();
        reset = 1'b0;
        #1;
        vectors++; if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL mid_rr_restart: got %b want 0001", bus.gnt); end
        tick();
        vectors++; if (bus.data_bus !== 16'hFA51 || bus.valid !== 1'b1) begin
            miscompares++; $display("FAIL mid_seq1: got %h/%b want FA51/1", bus.data_bus, bus.valid); end
        bus.req = '0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        bus.req = '0; bus.payload = '0; bus.err_in = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_err_resync();
        test_err_with_req();
        test_reset_mid();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
